// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM state type and iteration count for muldiv_unit.
// Signed codes (mult/divs) are accepted only when MULDIV_SIGNED_EN is defined.
package muldiv_pkg;

   localparam logic [5:0] FUNCT_MUL    = 6'b011000;
   localparam logic [5:0] FUNCT_MULT_S = 6'b011001;
   localparam logic [5:0] FUNCT_DIV    = 6'b011010;
   localparam logic [5:0] FUNCT_DIV_S  = 6'b011011;

   localparam int ITER_COUNT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   function automatic logic funct_is_valid(input logic [5:0] f);
`ifdef MULDIV_SIGNED_EN
      return (f == FUNCT_MUL) || (f == FUNCT_DIV) ||
             (f == FUNCT_MULT_S) || (f == FUNCT_DIV_S);
`else
      return (f == FUNCT_MUL) || (f == FUNCT_DIV);
`endif
   endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-divide step: trial subtract of the divisor from the
// already-shifted partial remainder, keeping the difference only when it does not borrow.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_diff;

   assign w_diff = i_rem - {1'b0, i_divisor};

   // i_rem never exceeds 2*divisor-1 (or 2^WIDTH-1 for a zero divisor), so the
   // top difference bit is exactly the borrow.
   assign o_qbit = ~w_diff[WIDTH];
   assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : i_rem[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, 17-cycle fixed latency.
// Optional signed mult/divs support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int FUNCT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [FUNCT_W-1:0]   funct,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   out,
   output logic                 zero,
   output logic                 div_by_zero
);

   localparam int CNT_W = $clog2(ITER_COUNT);

   muldiv_state_t        r_state;
   logic [CNT_W-1:0]     r_count;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_dbz;
   logic [2*WIDTH-1:0]   r_out;

   logic                 r_is_div;
   logic                 r_b_zero;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [WIDTH-1:0]     r_a_orig;

   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;

   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quo;
   logic [WIDTH-1:0]     r_divisor;

   logic                 w_start_ok;
   logic                 w_is_div;
   logic                 w_is_signed;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [WIDTH:0]       w_shift_rem;
   logic [WIDTH-1:0]     w_rem_next;
   logic                 w_qbit;
   logic [WIDTH-1:0]     w_quo_next;
   logic [WIDTH-1:0]     w_quo_fin;
   logic [WIDTH-1:0]     w_rem_fin;
   logic [2*WIDTH-1:0]   w_mul_fin;
   logic [2*WIDTH-1:0]   w_result;

   assign w_start_ok = start && funct_is_valid(funct);
   assign w_is_div   = (funct == FUNCT_DIV) || (funct == FUNCT_DIV_S);

`ifdef MULDIV_SIGNED_EN
   assign w_is_signed = (funct == FUNCT_MULT_S) || (funct == FUNCT_DIV_S);
`else
   assign w_is_signed = 1'b0;
`endif

   // Signed operands run through the unsigned datapath as magnitudes.
   assign w_mag_a = (w_is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign w_mag_b = (w_is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem     (w_shift_rem),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_next),
      .o_qbit    (w_qbit)
   );

   assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

   assign w_quo_fin = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
   assign w_rem_fin = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
   assign w_mul_fin = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;

   always_comb begin
      w_result = w_mul_fin;
      if (r_is_div) begin
         // A zero divisor reports the original dividend, signed or not.
         if (r_b_zero) begin
            w_result = {r_a_orig, {WIDTH{1'b1}}};
         end else begin
            w_result = {w_rem_fin, w_quo_fin};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dbz     <= 1'b0;
         r_out     <= '0;
         r_is_div  <= 1'b0;
         r_b_zero  <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_a_orig  <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
      end else begin
         case (r_state)
            BUSY: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_rem    <= w_rem_next;
               r_quo    <= w_quo_next;
               if (r_count == CNT_W'(ITER_COUNT - 1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_out   <= w_result;
                  r_dbz   <= r_is_div && r_b_zero;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: begin
               r_done <= 1'b0;
               if (w_start_ok) begin
                  r_state   <= BUSY;
                  r_busy    <= 1'b1;
                  r_count   <= '0;
                  r_dbz     <= 1'b0;
                  r_is_div  <= w_is_div;
                  r_b_zero  <= (b == '0);
                  r_neg_q   <= w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_r   <= w_is_signed && w_is_div && a[WIDTH-1];
                  r_a_orig  <= a;
                  r_acc     <= '0;
                  r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier  <= w_mag_b;
                  r_rem     <= '0;
                  r_quo     <= w_mag_a;
                  r_divisor <= w_mag_b;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign out         = r_out;
   assign zero        = (r_out == '0);
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations against an arithmetic model.
// Signed cases are exercised when MULDIV_SIGNED_EN is defined; otherwise signed codes must be ignored.
module tb_muldiv_unit;

   localparam logic [5:0] F_MUL  = 6'b011000;
   localparam logic [5:0] F_MULS = 6'b011001;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_DIVS = 6'b011011;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic [5:0]  funct;
   logic        busy;
   logic        done;
   logic [31:0] out;
   logic        zero;
   logic        div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit #(.WIDTH(16), .FUNCT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .funct       (funct),
      .busy        (busy),
      .done        (done),
      .out         (out),
      .zero        (zero),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference results from plain integer arithmetic.
   function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic [5:0] f);
      int unsigned ux, uy;
      int sx, sy, q, r;
      logic [31:0] res;
      ux = {16'd0, x};
      uy = {16'd0, y};
      sx = int'($signed(x));
      sy = int'($signed(y));
      res = 32'd0;
      if (f == F_MUL) begin
         res = ux * uy;
      end else if (f == F_MULS) begin
         res = sx * sy;
      end else if (y == 16'd0) begin
         res = {x, 16'hFFFF};
      end else if (f == F_DIV) begin
         q = int'(ux / uy);
         r = int'(ux % uy);
         res = {r[15:0], q[15:0]};
      end else begin
         q = sx / sy;
         r = sx % sy;
         res = {r[15:0], q[15:0]};
      end
      return res;
   endfunction

   // Called at a falling edge; issues start now and returns at the falling edge of the DONE cycle.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic [5:0] tf,
                         input logic [31:0] exp_out, input bit mid_start, input string tag);
      logic exp_dbz;
      exp_dbz = ((tf == F_DIV) || (tf == F_DIVS)) && (tbv == 16'd0);
      start = 1'b1;
      a = ta;
      b = tbv;
      funct = tf;
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      funct = F_MUL;
      check({tag, "_busy_e0"}, 32'(busy), 32'd1);
      check({tag, "_dbz_cleared"}, 32'(div_by_zero), 32'd0);
      for (int i = 1; i <= 15; i++) begin
         if (mid_start && i == 5) begin
            start = 1'b1;
            funct = F_DIV;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "_busy_e15"}, 32'(busy), 32'd1);
      check({tag, "_done_e15"}, 32'(done), 32'd0);
      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_out"}, out, exp_out);
      check({tag, "_zero"}, 32'(zero), 32'(exp_out == 32'd0));
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
      $display("op %s a=%h b=%h funct=%b out=%h expected=%h", tag, ta, tbv, tf, out, exp_out);
   endtask

   task automatic settle(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic [5:0]  rf;
      logic [31:0] keep_out;
      bit          saw_busy, saw_done;

      rst = 1'b1;
      start = 1'b0;
      a = 16'd0;
      b = 16'd0;
      funct = 6'd0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_out", out, 32'd0);
      check("reset_zero", 32'(zero), 32'd1);
      check("reset_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(16'd300, 16'd250, F_MUL, 32'd75000, 1'b1, "mul_300x250");
      settle("mul_300x250");
      check("out_hold", out, 32'd75000);

      run_op(16'd1000, 16'd7, F_DIV, {16'd6, 16'd142}, 1'b0, "div_1000_7");
      settle("div_1000_7");

      run_op(16'd1234, 16'd0, F_DIV, {16'd1234, 16'hFFFF}, 1'b0, "div_1234_0");
      run_op(16'd0, 16'd5, F_MUL, 32'd0, 1'b0, "mul_0x5_b2b");
      settle("mul_0x5_b2b");

`ifdef MULDIV_SIGNED_EN
      run_op(16'hFFF9, 16'd2, F_DIVS, {16'hFFFF, 16'hFFFD}, 1'b0, "divs_m7_2");
      settle("divs_m7_2");
      run_op(16'hFFFD, 16'd4, F_MULS, 32'hFFFFFFF4, 1'b0, "mult_m3x4");
      settle("mult_m3x4");
      run_op(16'h8000, 16'hFFFF, F_DIVS, {16'h0000, 16'h8000}, 1'b0, "divs_min_m1");
      settle("divs_min_m1");
      run_op(16'hFFF9, 16'd0, F_DIVS, {16'hFFF9, 16'hFFFF}, 1'b0, "divs_m7_0");
      settle("divs_m7_0");
`else
      keep_out = out;
      start = 1'b1;
      a = 16'd9;
      b = 16'd9;
      funct = F_MULS;
      @(negedge clk);
      check("inv_mults_busy", 32'(busy), 32'd0);
      funct = 6'b000000;
      saw_busy = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 1) funct = F_DIVS;
         if (busy) saw_busy = 1'b1;
         if (done) saw_done = 1'b1;
      end
      start = 1'b0;
      check("inv_funct_no_busy", 32'(saw_busy), 32'd0);
      check("inv_funct_no_done", 32'(saw_done), 32'd0);
      check("inv_funct_out_kept", out, keep_out);
      $display("op invalid funct codes ignored busy_seen=%0d done_seen=%0d", saw_busy, saw_done);
      @(negedge clk);
`endif

      for (int n = 0; n < 30; n++) begin
`ifdef MULDIV_SIGNED_EN
         case ($urandom_range(0, 3))
            0: rf = F_MUL;
            1: rf = F_DIV;
            2: rf = F_MULS;
            default: rf = F_DIVS;
         endcase
`else
         rf = ($urandom_range(0, 1) == 0) ? F_MUL : F_DIV;
`endif
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) rb = 16'd0;
         run_op(ra, rb, rf, model(ra, rb, rf), 1'b0, "rand");
         if ($urandom_range(0, 1) == 0) settle("rand");
      end
      settle("rand_end");

      run_op(16'd3, 16'd5, F_MUL, 32'd15, 1'b0, "mul_3x5");
      settle("mul_3x5");
      start = 1'b1;
      a = 16'd1234;
      b = 16'd4321;
      funct = F_MUL;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_out", out, 32'd0);
      check("rst_mid_zero", 32'(zero), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      saw_busy = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
         if (done) saw_done = 1'b1;
      end
      check("rst_mid_no_busy", 32'(saw_busy), 32'd0);
      check("rst_mid_no_done", 32'(saw_done), 32'd0);
      $display("op reset mid-operation done_seen=%0d out=%h", saw_done, out);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
